// File: rtl/pad_ctrl_pkg.sv
// Shared types and defaults for the pad direction controller.
// Holds the pad count, the FSM state encoding and the boot configuration.
package pad_ctrl_pkg;

    localparam int N_PADS = 15;

    localparam logic [N_PADS-1:0] BOOT_OE_DEFAULT = 15'h7FF0;
    localparam logic [N_PADS-1:0] BOOT_PU_DEFAULT = 15'h0000;
    localparam logic [N_PADS-1:0] BOOT_PD_DEFAULT = 15'h0000;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_OE_OFF,
        ST_TURN,
        ST_SWITCH,
        ST_SETTLE,
        ST_OE_ON
    } state_t;

    // Response still owed for a request that was handled without a sequence.
    typedef enum logic [1:0] {
        RSP_NONE,
        RSP_DONE,
        RSP_ERR
    } rsp_t;

    typedef struct packed {
        logic [N_PADS-1:0] oe;
        logic [N_PADS-1:0] pu;
        logic [N_PADS-1:0] pd;
    } pad_cfg_t;

    function automatic logic pull_conflict(input pad_cfg_t cfg);
        return |(cfg.pu & cfg.pd);
    endfunction

endpackage

// File: rtl/pad_turn_timer.sv
// Loadable down-counter timing the TURN and SETTLE phases.
// Saturates at zero; zero is flagged combinationally from the count.
module pad_turn_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pad_dir_ctrl.sv
// Break-before-make sequencer for bidirectional pad direction and pulls.
// Output enables drop first, inputs/pulls switch after a turnaround, new enables last.
module pad_dir_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter int                TURN_CYC = 4,
    parameter logic [N_PADS-1:0] BOOT_OE  = BOOT_OE_DEFAULT,
    parameter logic [N_PADS-1:0] BOOT_PU  = BOOT_PU_DEFAULT,
    parameter logic [N_PADS-1:0] BOOT_PD  = BOOT_PD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [N_PADS-1:0] cfg_oe,
    input  logic [N_PADS-1:0] cfg_pu,
    input  logic [N_PADS-1:0] cfg_pd,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic              busy,
    output logic [N_PADS-1:0] oe_bidir,
    output logic [N_PADS-1:0] ie_bidir,
    output logic [N_PADS-1:0] pu_bidir,
    output logic [N_PADS-1:0] pd_bidir
);

    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYC - 1);

    state_t            state_q, state_d;
    rsp_t              rsp_q, rsp_d;
    pad_cfg_t          target_q, target_d;
    pad_cfg_t          req;
    logic [N_PADS-1:0] oe_q, oe_d, ie_q, ie_d, pu_q, pu_d, pd_q, pd_d;
    logic              ready_q, ready_d, done_q, done_d;
    logic              err_q, err_d, busy_q, busy_d;
    logic              tmr_load, tmr_dec, tmr_zero;

    assign req = '{oe: cfg_oe, pu: cfg_pu, pd: cfg_pd};

    pad_turn_timer #(.W(8)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (TURN_LOAD),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        rsp_d    = RSP_NONE;
        target_d = target_q;
        oe_d     = oe_q;
        ie_d     = ie_q;
        pu_d     = pu_q;
        pd_d     = pd_q;
        ready_d  = ready_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                target_d = '{oe: BOOT_OE, pu: BOOT_PU, pd: BOOT_PD};
                busy_d   = 1'b1;
                ready_d  = 1'b0;
                state_d  = ST_OE_OFF;
            end
            ST_IDLE: begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
                done_d  = (rsp_q == RSP_DONE);
                err_d   = (rsp_q == RSP_ERR);
                // ready drops for one cycle so a held request is not re-taken
                // before its response pulse has gone out.
                if (cfg_valid && ready_q) begin
                    ready_d = 1'b0;
                    if (pull_conflict(req)) begin
                        rsp_d = RSP_ERR;
                    end else if (req == target_q) begin
                        rsp_d = RSP_DONE;
                    end else begin
                        target_d = req;
                        busy_d   = 1'b1;
                        state_d  = ST_OE_OFF;
                    end
                end
            end
            ST_OE_OFF: begin
                oe_d     = oe_q & target_q.oe;
                tmr_load = 1'b1;
                state_d  = ST_TURN;
            end
            ST_TURN: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_d = ST_SWITCH;
            end
            ST_SWITCH: begin
                ie_d     = ~target_q.oe;
                pu_d     = target_q.pu & ~target_q.oe;
                pd_d     = target_q.pd & ~target_q.oe;
                tmr_load = 1'b1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_dec = 1'b1;
                if (tmr_zero) state_d = ST_OE_ON;
            end
            ST_OE_ON: begin
                oe_d    = target_q.oe;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_BOOT;
            rsp_q    <= RSP_NONE;
            target_q <= '0;
            oe_q     <= '0;
            ie_q     <= '1;
            pu_q     <= '0;
            pd_q     <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rsp_q    <= rsp_d;
            target_q <= target_d;
            oe_q     <= oe_d;
            ie_q     <= ie_d;
            pu_q     <= pu_d;
            pd_q     <= pd_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    assign cfg_ready = ready_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign busy      = busy_q;
    assign oe_bidir  = oe_q;
    assign ie_bidir  = ie_q;
    assign pu_bidir  = pu_q;
    assign pd_bidir  = pd_q;

endmodule
